// File: rtl/execute_pipe.sv
// rtl/execute_pipe.sv - execute stage: forwarding, ALU, registered output slot with valid/ready
// Optional radix-2 iterative multiplier enabled by defining EXECUTE_PIPE_MUL_EN.
module execute_pipe #(
  parameter int DATA_W    = 16,
  parameter int REG_IDX_W = 3,
  parameter int NUM_FWD   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [3:0]                    in_op,
  input  logic [REG_IDX_W-1:0]          in_rs_idx,
  input  logic [REG_IDX_W-1:0]          in_rt_idx,
  input  logic [DATA_W-1:0]             in_rs_data,
  input  logic [DATA_W-1:0]             in_rt_data,
  input  logic [DATA_W-1:0]             in_imm,
  input  logic                          in_use_imm,
  input  logic [REG_IDX_W-1:0]          in_dest_idx,
  input  logic                          in_dest_wr,
  input  logic                          in_ldst,
  input  logic [1:0]                    in_store,
  input  logic [NUM_FWD-1:0]            fwd_valid,
  input  logic [NUM_FWD*REG_IDX_W-1:0]  fwd_idx,
  input  logic [NUM_FWD*DATA_W-1:0]     fwd_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_result,
  output logic [DATA_W-1:0]             out_store_data,
  output logic [REG_IDX_W-1:0]          out_dest_idx,
  output logic                          out_dest_wr,
  output logic                          out_ldst,
  output logic [1:0]                    out_store,
  output logic                          out_excep,
  output logic                          busy
);

  localparam int SH_W = $clog2(DATA_W);

  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3,
                         OP_XOR = 4'h4, OP_SLL = 4'h5, OP_SRL = 4'h6, OP_SRA = 4'h7,
                         OP_ROL = 4'h8, OP_ROR = 4'h9, OP_SLT = 4'hA, OP_PASSB = 4'hB,
                         OP_MUL = 4'hC;

  typedef enum logic [1:0] {S_IDLE, S_FULL, S_MUL} state_e;

  state_e                state_q;
  logic [DATA_W-1:0]     result_q;
  logic [DATA_W-1:0]     store_data_q;
  logic [REG_IDX_W-1:0]  dest_idx_q;
  logic                  dest_wr_q;
  logic                  ldst_q;
  logic [1:0]            store_q;
  logic                  excep_q;

  logic [DATA_W-1:0]     op_a;
  logic [DATA_W-1:0]     rt_fwd;
  logic [DATA_W-1:0]     op_b;
  logic [SH_W-1:0]       amt;
  logic [2*DATA_W-1:0]   rot_l;
  logic [2*DATA_W-1:0]   rot_r;
  logic [DATA_W-1:0]     result_d;
  logic                  excep_d;
  logic                  accept;
  logic                  mul_start;
  logic                  mul_done;
  logic [DATA_W-1:0]     mul_sum;

  // Walk from the oldest entry down so the lowest-numbered match wins.
  always_comb begin
    op_a   = in_rs_data;
    rt_fwd = in_rt_data;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_valid[i] && (fwd_idx[i*REG_IDX_W +: REG_IDX_W] == in_rs_idx))
        op_a = fwd_data[i*DATA_W +: DATA_W];
      if (fwd_valid[i] && (fwd_idx[i*REG_IDX_W +: REG_IDX_W] == in_rt_idx))
        rt_fwd = fwd_data[i*DATA_W +: DATA_W];
    end
  end

  assign op_b  = in_use_imm ? in_imm : rt_fwd;
  assign amt   = op_b[SH_W-1:0];
  assign rot_l = {op_a, op_a} << amt;
  assign rot_r = {op_a, op_a} >> amt;

  always_comb begin
    result_d = '0;
    excep_d  = 1'b0;
    case (in_op)
      OP_ADD:   result_d = op_a + op_b;
      OP_SUB:   result_d = op_a - op_b;
      OP_AND:   result_d = op_a & op_b;
      OP_OR:    result_d = op_a | op_b;
      OP_XOR:   result_d = op_a ^ op_b;
      OP_SLL:   result_d = op_a << amt;
      OP_SRL:   result_d = op_a >> amt;
      OP_SRA:   result_d = $signed(op_a) >>> amt;
      OP_ROL:   result_d = rot_l[2*DATA_W-1:DATA_W];
      OP_ROR:   result_d = rot_r[DATA_W-1:0];
      OP_SLT:   result_d = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_PASSB: result_d = op_b;
`ifdef EXECUTE_PIPE_MUL_EN
      OP_MUL:   result_d = '0;
`endif
      default:  excep_d  = 1'b1;
    endcase
  end

  assign in_ready = !flush && (state_q != S_MUL) && ((state_q == S_IDLE) || out_ready);
  assign accept   = in_valid && in_ready;

`ifdef EXECUTE_PIPE_MUL_EN
  logic [DATA_W-1:0] mcand_q;
  logic [DATA_W-1:0] mplier_q;
  logic [DATA_W-1:0] acc_q;
  logic [SH_W-1:0]   cnt_q;

  assign mul_start = (in_op == OP_MUL);
  assign mul_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_done  = (state_q == S_MUL) && (cnt_q == '0);
  assign busy      = (state_q == S_MUL);

  // One multiplier bit per cycle; only the low DATA_W bits are kept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (accept && mul_start) begin
      mcand_q  <= op_a;
      mplier_q <= op_b;
      acc_q    <= '0;
      cnt_q    <= SH_W'(DATA_W - 1);
    end else if (state_q == S_MUL) begin
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      acc_q    <= mul_sum;
      cnt_q    <= cnt_q - 1'b1;
    end
  end
`else
  assign mul_start = 1'b0;
  assign mul_sum   = '0;
  assign mul_done  = 1'b0;
  assign busy      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      result_q     <= '0;
      store_data_q <= '0;
      dest_idx_q   <= '0;
      dest_wr_q    <= 1'b0;
      ldst_q       <= 1'b0;
      store_q      <= 2'b00;
      excep_q      <= 1'b0;
    end else if (flush) begin
      state_q <= S_IDLE;
    end else if (accept) begin
      store_data_q <= rt_fwd;
      dest_idx_q   <= in_dest_idx;
      dest_wr_q    <= in_dest_wr && !excep_d;
      ldst_q       <= in_ldst;
      store_q      <= in_store;
      excep_q      <= excep_d;
      result_q     <= result_d;
      state_q      <= mul_start ? S_MUL : S_FULL;
    end else if (mul_done) begin
      result_q <= mul_sum;
      state_q  <= S_FULL;
    end else if ((state_q == S_FULL) && out_ready) begin
      state_q <= S_IDLE;
    end
  end

  assign out_valid      = (state_q == S_FULL);
  assign out_result     = result_q;
  assign out_store_data = store_data_q;
  assign out_dest_idx   = dest_idx_q;
  assign out_dest_wr    = dest_wr_q;
  assign out_ldst       = ldst_q;
  assign out_store      = store_q;
  assign out_excep      = excep_q;

endmodule

// File: tb/tb_execute_pipe.sv
// tb/tb_execute_pipe.sv - directed and random checks of execute_pipe against a behavioural model
module tb_execute_pipe;
  localparam int W = 16, IW = 3, NF = 2;
`ifdef EXECUTE_PIPE_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flush, in_valid, in_ready, in_use_imm, in_dest_wr, in_ldst;
  logic [3:0] in_op;
  logic [IW-1:0] in_rs_idx, in_rt_idx, in_dest_idx, out_dest_idx;
  logic [W-1:0] in_rs_data, in_rt_data, in_imm, out_result, out_store_data;
  logic [1:0] in_store, out_store;
  logic [NF-1:0] fwd_valid;
  logic [NF*IW-1:0] fwd_idx;
  logic [NF*W-1:0] fwd_data;
  logic out_valid, out_ready, out_dest_wr, out_ldst, out_excep, busy;

  execute_pipe dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs_idx(in_rs_idx), .in_rt_idx(in_rt_idx), .in_rs_data(in_rs_data),
    .in_rt_data(in_rt_data), .in_imm(in_imm), .in_use_imm(in_use_imm),
    .in_dest_idx(in_dest_idx), .in_dest_wr(in_dest_wr), .in_ldst(in_ldst),
    .in_store(in_store), .fwd_valid(fwd_valid), .fwd_idx(fwd_idx), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_store_data(out_store_data), .out_dest_idx(out_dest_idx), .out_dest_wr(out_dest_wr),
    .out_ldst(out_ldst), .out_store(out_store), .out_excep(out_excep), .busy(busy)
  );

  typedef struct {
    logic [W-1:0]  res;
    logic [W-1:0]  sd;
    logic [IW-1:0] dest;
    logic          wr;
    logic          ldst;
    logic [1:0]    st;
    logic          exc;
  } beat_t;

  int n_vec = 0, n_err = 0;
  bit m_valid = 0;
  int mul_left = 0;
  beat_t m_beat, m_pend;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned resolve(logic [IW-1:0] idx, logic [W-1:0] rf);
    for (int i = 0; i < NF; i++)
      if (fwd_valid[i] && fwd_idx[i*IW +: IW] == idx) return fwd_data[i*W +: W];
    return rf;
  endfunction

  function automatic beat_t ref_beat();
    beat_t bt;
    int unsigned a, breg, b, r, amt;
    int sa, sb;
    bit exc;
    a = resolve(in_rs_idx, in_rs_data);
    breg = resolve(in_rt_idx, in_rt_data);
    b = in_use_imm ? in_imm : breg;
    amt = b % W;
    sa = (a >= 32768) ? int'(a) - 65536 : int'(a);
    sb = (b >= 32768) ? int'(b) - 65536 : int'(b);
    exc = 0;
    r = 0;
    case (in_op)
      4'd0:  r = (a + b) % 65536;
      4'd1:  r = (a + 65536 - b) % 65536;
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = (a << amt) % 65536;
      4'd6:  r = a >> amt;
      4'd7:  r = (sa >>> amt) & 65535;
      4'd8:  begin r = a; repeat (amt) r = ((r << 1) | (r >> 15)) & 65535; end
      4'd9:  begin r = a; repeat (amt) r = (r >> 1) | ((r & 1) << 15); end
      4'd10: r = (sa < sb) ? 1 : 0;
      4'd11: r = b;
      4'd12: if (MUL_ON) r = (a * b) % 65536; else exc = 1;
      default: exc = 1;
    endcase
    if (exc) r = 0;
    bt.res = r[W-1:0];
    bt.sd = breg[W-1:0];
    bt.dest = in_dest_idx;
    bt.wr = in_dest_wr && !exc;
    bt.ldst = in_ldst;
    bt.st = in_store;
    bt.exc = exc;
    return bt;
  endfunction

  task automatic check_out();
    check("out_valid", out_valid, m_valid);
    check("busy", busy, mul_left > 0);
    if (m_valid) begin
      check("result", out_result, m_beat.res);
      check("store_data", out_store_data, m_beat.sd);
      check("dest_idx", out_dest_idx, m_beat.dest);
      check("dest_wr", out_dest_wr, m_beat.wr);
      check("ldst", out_ldst, m_beat.ldst);
      check("store", out_store, m_beat.st);
      check("excep", out_excep, m_beat.exc);
    end
  endtask

  // One clock: check in_ready, advance the model by the handshake rules, check outputs.
  task automatic tick();
    bit exp_rdy, acc, dlv, fl, is_mul;
    beat_t nb;
    #1;
    exp_rdy = !flush && mul_left == 0 && (!m_valid || out_ready);
    check("in_ready", in_ready, exp_rdy);
    acc = in_valid && exp_rdy;
    dlv = m_valid && out_ready;
    fl = flush;
    is_mul = MUL_ON && in_op == 4'd12;
    nb = ref_beat();
    @(posedge clk); #1;
    if (fl) begin
      m_valid = 0;
      mul_left = 0;
    end else begin
      if (dlv) m_valid = 0;
      if (acc) begin
        if (is_mul) begin mul_left = W; m_pend = nb; end
        else begin m_valid = 1; m_beat = nb; end
      end else if (mul_left > 0) begin
        mul_left--;
        if (mul_left == 0) begin m_valid = 1; m_beat = m_pend; end
      end
    end
    check_out();
  endtask

  task automatic set_op(logic [3:0] op, logic [IW-1:0] rsi, logic [IW-1:0] rti,
                        logic [W-1:0] rs, logic [W-1:0] rt, logic [W-1:0] imm,
                        logic use_imm, logic [IW-1:0] dest);
    in_valid = 1; in_op = op; in_rs_idx = rsi; in_rt_idx = rti;
    in_rs_data = rs; in_rt_data = rt; in_imm = imm; in_use_imm = use_imm;
    in_dest_idx = dest; in_dest_wr = 1; in_ldst = 0; in_store = 2'b00;
  endtask

  initial begin
    rst = 0; flush = 0; in_valid = 0; out_ready = 1;
    set_op(0, 0, 0, 0, 0, 0, 0, 0); in_valid = 0;
    fwd_valid = '0; fwd_idx = '0; fwd_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_result", out_result, 0);
    check("rst_dest_wr", out_dest_wr, 0);
    check("rst_excep", out_excep, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 1;

    // ADD, latency 1
    set_op(0, 1, 2, 16'h0003, 16'h0004, 0, 0, 2); tick(); in_valid = 0;
    check("add_res", out_result, 16'h0007);
    check("add_dest", out_dest_idx, 2);
    check("add_wr", out_dest_wr, 1);
    tick();

    // forwarding priority
    fwd_valid = 2'b11; fwd_idx = {3'd1, 3'd1}; fwd_data = {16'hBBBB, 16'hAAAA};
    set_op(4'hB, 1, 1, 16'h1111, 16'h1111, 0, 0, 3); tick();
    check("fwd0", out_result, 16'hAAAA);
    fwd_valid = 2'b10; tick();
    check("fwd1", out_result, 16'hBBBB);
    fwd_valid = 2'b01; fwd_idx = {3'd5, 3'd0};
    set_op(4'hB, 0, 0, 16'h1111, 16'h2222, 0, 0, 3); tick();
    check("fwd_idx0", out_result, 16'hAAAA);
    in_valid = 0; fwd_valid = '0; tick();

    // backpressure with back-to-back beats
    out_ready = 0;
    set_op(0, 1, 2, 1, 1, 0, 0, 1); tick();
    set_op(0, 1, 2, 2, 2, 0, 0, 2);
    repeat (3) begin tick(); check("hold_res", out_result, 16'h0002); end
    out_ready = 1; tick();
    check("b2b_2", out_result, 16'h0004);
    set_op(0, 1, 2, 3, 3, 0, 0, 3); tick();
    check("b2b_3", out_result, 16'h0006);
    in_valid = 0; tick();

    // shift/rotate/arith corners
    set_op(4'h9, 1, 2, 16'h8001, 0, 1, 1, 1); tick();
    check("ror", out_result, 16'hC000);
    set_op(4'h7, 1, 2, 16'h8000, 0, 15, 1, 1); tick();
    check("sra", out_result, 16'hFFFF);
    set_op(4'h1, 1, 2, 16'h0000, 0, 1, 1, 1); tick();
    check("sub", out_result, 16'hFFFF);
    set_op(4'hA, 1, 2, 16'hFFFF, 0, 1, 1, 1); tick();
    check("slt", out_result, 16'h0001);
    set_op(4'hE, 1, 2, 16'h1234, 0, 1, 1, 1); tick();
    check("illegal_exc", out_excep, 1);
    in_valid = 0; tick();

    // multiplier
    set_op(4'hC, 1, 2, 16'h0012, 16'h0034, 0, 0, 4); tick(); in_valid = 0;
`ifdef EXECUTE_PIPE_MUL_EN
    repeat (W) tick();
    check("mul_res", out_result, 16'h03A8);
    check("mul_valid", out_valid, 1);
    tick();
    set_op(4'hC, 1, 2, 16'h0012, 16'h0034, 0, 0, 4); tick(); in_valid = 0;
    repeat (3) tick();
    flush = 1; set_op(0, 1, 2, 7, 7, 0, 0, 1); tick();
    flush = 0; in_valid = 0;
    check("mul_flush_busy", busy, 0);
    repeat (W) tick();
    set_op(0, 1, 2, 5, 6, 0, 0, 1); tick(); in_valid = 0;
    check("after_flush_add", out_result, 16'd11);
    tick();
`else
    check("mul_exc", out_excep, 1);
    check("mul_wr", out_dest_wr, 0);
    check("mul_res0", out_result, 0);
    tick();
`endif

    // flush of a stalled full slot, with a beat offered in the same cycle
    out_ready = 0;
    set_op(0, 1, 2, 9, 9, 0, 0, 1); tick();
    flush = 1; set_op(0, 1, 2, 1, 2, 0, 0, 2); tick();
    flush = 0; in_valid = 0;
    check("flush_valid", out_valid, 0);
    tick();

    // asynchronous reset while stalled
    set_op(0, 1, 2, 4, 4, 0, 0, 1); tick(); in_valid = 0;
    #2 rst = 0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_res", out_result, 0);
    m_valid = 0; mul_left = 0;
    @(posedge clk); #1;
    rst = 1; out_ready = 1;
    #1;
    check("post_rst_ready", in_ready, 1);
    tick();

    // random traffic
    for (int n = 0; n < 500; n++) begin
      flush = ($urandom_range(0, 24) == 0);
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      in_op = 4'($urandom_range(0, 15));
      in_rs_idx = 3'($urandom); in_rt_idx = 3'($urandom); in_dest_idx = 3'($urandom);
      in_rs_data = 16'($urandom); in_rt_data = 16'($urandom); in_imm = 16'($urandom);
      in_use_imm = 1'($urandom); in_dest_wr = 1'($urandom); in_ldst = 1'($urandom);
      in_store = 2'($urandom);
      fwd_valid = 2'($urandom); fwd_idx = 6'($urandom); fwd_data = $urandom;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
